tdm_demux4: RTL and testbench



---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_decoder.sv | 21 ++
 rtl/tdm_demux4.sv | 138 +++++++++++++
 tb/tb_tdm_demux4.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot serial TDM link (transmit mux and receive demux).
// slot_to_chan lives here so both ends of the link use one mapping.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slot s on the wire carries channel 3-s.
  function automatic logic [SLOT_W-1:0] slot_to_chan(input logic [SLOT_W-1:0] s);
    return SLOT_W'(NUM_SLOTS - 1) - s;
  endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// One-hot shift-enable decoder: selects the channel register fed by the current slot.
// Outputs are already in channel order (slot s enables channel 3-s).
module tdm_slot_decoder
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] shift_en
);

  logic [SLOT_W-1:0] chan;

  assign chan = slot_to_chan(slot);

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
      assign shift_en[gi] = en && (chan == SLOT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/tdm_demux4.sv
// Serial 4-slot TDM demultiplexer: steers each bit into its channel shift register and
// publishes all four words together after WIDTH frames.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Sync,
  input  logic             w,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             Valid,
  output logic             SyncErr,
  output logic             Busy
);

  localparam int FRAME_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(WIDTH - 1);
  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

  state_t              state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [FRAME_W-1:0]  frame_reg, frame_next;
  logic [WIDTH-1:0]    sr_reg  [NUM_SLOTS];
  logic [WIDTH-1:0]    sr_next [NUM_SLOTS];
  logic [WIDTH-1:0]    sr_base [NUM_SLOTS];
  logic [WIDTH-1:0]    q_reg   [NUM_SLOTS];
  logic [WIDTH-1:0]    q_next  [NUM_SLOTS];
  logic                valid_reg, valid_next;
  logic                sync_err_reg, sync_err_next;
  logic                busy_reg, busy_next;

  logic                 sampling;
  logic                 resync;
  logic                 publish;
  logic [SLOT_W-1:0]    dec_slot;
  logic [NUM_SLOTS-1:0] shift_en;

  // A Sync that starts a group: the first one from IDLE, or a misaligned one in RUN.
  // Either way the current bit becomes slot 0 of frame 0 on cleared registers.
  assign resync   = En && Sync && ((state_reg == IDLE) || (slot_reg != '0));
  assign sampling = En && ((state_reg == RUN) || Sync);
  assign dec_slot = resync ? '0 : slot_reg;
  assign publish  = En && (state_reg == RUN) && !resync &&
                    (slot_reg == LAST_SLOT) && (frame_reg == LAST_FRAME);

  tdm_slot_decoder u_dec (
    .slot     (dec_slot),
    .en       (sampling),
    .shift_en (shift_en)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_chan
      assign sr_base[gi] = resync ? '0 : sr_reg[gi];

      always_comb begin
        sr_next[gi] = sr_base[gi];
        if (shift_en[gi]) begin
          sr_next[gi] = {sr_base[gi][WIDTH-2:0], w};
        end
      end

      // The publishing edge's own bit is already in sr_next.
      always_comb begin
        q_next[gi] = q_reg[gi];
        if (publish) begin
          q_next[gi] = sr_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg    <= IDLE;
      slot_reg     <= '0;
      frame_reg    <= '0;
      valid_reg    <= 1'b0;
      sync_err_reg <= 1'b0;
      busy_reg     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sr_reg[i] <= '0;
        q_reg[i]  <= '0;
      end
    end else begin
      state_reg    <= state_next;
      slot_reg     <= slot_next;
      frame_reg    <= frame_next;
      valid_reg    <= valid_next;
      sync_err_reg <= sync_err_next;
      busy_reg     <= busy_next;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sr_reg[i] <= sr_next[i];
        q_reg[i]  <= q_next[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    frame_next = frame_reg;
    if (En) begin
      if (resync) begin
        state_next = RUN;
        slot_next  = SLOT_W'(1);
        frame_next = '0;
      end else if (state_reg == RUN) begin
        // The 2-bit slot counter wraps 3->0 by itself, which also covers publication.
        slot_next = slot_reg + SLOT_W'(1);
        if (slot_reg == LAST_SLOT) begin
          frame_next = (frame_reg == LAST_FRAME) ? '0 : frame_reg + FRAME_W'(1);
        end
      end
    end
  end

  always_comb begin
    valid_next    = publish;
    sync_err_next = resync && (state_reg == RUN);
    busy_next     = (state_next == RUN);
  end

  assign Q0      = q_reg[0];
  assign Q1      = q_reg[1];
  assign Q2      = q_reg[2];
  assign Q3      = q_reg[3];
  assign Valid   = valid_reg;
  assign SyncErr = sync_err_reg;
  assign Busy    = busy_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scenario bench for tdm_demux4: expected publications are queued with their due cycle
// and matched against Valid/Q0..Q3 after every clock edge.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         En = 1'b0;
  logic         Sync = 1'b0;
  logic         w = 1'b0;
  logic [W-1:0] Q0, Q1, Q2, Q3;
  logic         Valid, SyncErr, Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q0;
    logic [W-1:0] q1;
    logic [W-1:0] q2;
    logic [W-1:0] q3;
    int           due;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .En      (En),
    .Sync    (Sync),
    .w       (w),
    .Q0      (Q0),
    .Q1      (Q1),
    .Q2      (Q2),
    .Q3      (Q3),
    .Valid   (Valid),
    .SyncErr (SyncErr),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  // One clock edge of stimulus, then scoreboard comparison 1 time unit later.
  task automatic step(input logic rstn, input logic en, input logic sync,
                      input logic bit_in, input logic serr_exp);
    exp_t e;
    logic v_exp;
    Resetn = rstn;
    En     = en;
    Sync   = sync;
    w      = bit_in;
    @(posedge Clock);
    cyc++;
    #1;
    v_exp = (sb.size() > 0) && (sb[0].due == cyc);
    checks++;
    if (Valid !== v_exp) begin
      errors++;
      $display("FAIL valid cyc=%0d got %b expected %b", cyc, Valid, v_exp);
    end
    if (v_exp) begin
      e  = sb.pop_front();
      m0 = e.q0;
      m1 = e.q1;
      m2 = e.q2;
      m3 = e.q3;
    end
    checks++;
    if ({Q3, Q2, Q1, Q0} !== {m3, m2, m1, m0}) begin
      errors++;
      $display("FAIL q_words cyc=%0d got %h/%h/%h/%h expected %h/%h/%h/%h",
               cyc, Q3, Q2, Q1, Q0, m3, m2, m1, m0);
    end
    checks++;
    if (SyncErr !== serr_exp) begin
      errors++;
      $display("FAIL sync_err cyc=%0d got %b expected %b", cyc, SyncErr, serr_exp);
    end
  endtask

  // Serialise channel words MSB first: bit k is slot k%4 of frame k/4, slot s = channel 3-s.
  // Three En=0 cycles are inserted before each bit index listed in ga/gb/gc.
  task automatic send_group(input logic [W-1:0] c0, input logic [W-1:0] c1,
                            input logic [W-1:0] c2, input logic [W-1:0] c3,
                            input int nbits, input int ga, input int gb, input int gc,
                            input logic serr_first);
    logic [W-1:0] cw[4];
    cw[0] = c0;
    cw[1] = c1;
    cw[2] = c2;
    cw[3] = c3;
    for (int k = 0; k < nbits; k++) begin
      if (k == ga || k == gb || k == gc) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
      end
      step(1'b1, 1'b1, (k == 0), cw[3 - (k % 4)][W - 1 - (k / 4)], (k == 0) && serr_first);
      if (k == 0) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_first_edge cyc=%0d got %b expected 1", cyc, Busy);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [W-1:0] c0, input logic [W-1:0] c1,
                          input logic [W-1:0] c2, input logic [W-1:0] c3, input int due);
    exp_t e;
    e.q0  = c0;
    e.q1  = c1;
    e.q2  = c2;
    e.q3  = c3;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_publications got %0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    m0 = '0; m1 = '0; m2 = '0; m3 = '0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b expected 0", Busy);
    end
    $display("test_reset: cyc=%0d Q=%h/%h/%h/%h", cyc, Q3, Q2, Q1, Q0);
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy cyc=%0d got %b expected 0", cyc, Busy);
      end
    end
    $display("test_idle_ignore: 10 bits without Sync, cyc=%0d", cyc);
  endtask

  task automatic test_nominal();
    int t0;
    t0 = cyc;
    push_exp(8'h00, 8'hFF, 8'h3C, 8'hA5, t0 + 32);
    send_group(8'h00, 8'hFF, 8'h3C, 8'hA5, 32, -1, -1, -1, 1'b0);
    check_drained("nominal");
    $display("test_nominal: start=%0d Q=%h/%h/%h/%h", t0, Q3, Q2, Q1, Q0);
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    push_exp(8'hAA, 8'h55, 8'h80, 8'h01, t0 + 32);
    send_group(8'hAA, 8'h55, 8'h80, 8'h01, 32, -1, -1, -1, 1'b0);
    check_drained("back_to_back");
    $display("test_back_to_back: start=%0d Q=%h/%h/%h/%h", t0, Q3, Q2, Q1, Q0);
  endtask

  task automatic test_en_gaps();
    int t0;
    t0 = cyc;
    push_exp(8'h00, 8'hFF, 8'h3C, 8'hA5, t0 + 32 + 9);
    send_group(8'h00, 8'hFF, 8'h3C, 8'hA5, 32, 5, 15, 24, 1'b0);
    check_drained("en_gaps");
    $display("test_en_gaps: start=%0d Q=%h/%h/%h/%h", t0, Q3, Q2, Q1, Q0);
  endtask

  task automatic test_misaligned_sync();
    int t0;
    send_group(8'h44, 8'h33, 8'h22, 8'h11, 18, -1, -1, -1, 1'b0);
    t0 = cyc;
    push_exp(8'h96, 8'h0F, 8'h5A, 8'hC3, t0 + 32);
    send_group(8'h96, 8'h0F, 8'h5A, 8'hC3, 32, -1, -1, -1, 1'b1);
    check_drained("misaligned_sync");
    $display("test_misaligned_sync: start=%0d Q=%h/%h/%h/%h", t0, Q3, Q2, Q1, Q0);
  endtask

  task automatic test_reset_mid();
    int t0;
    send_group(8'h12, 8'h34, 8'h56, 8'h78, 20, -1, -1, -1, 1'b0);
    m0 = '0; m1 = '0; m2 = '0; m3 = '0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy got %b expected 0", Busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle_busy cyc=%0d got %b expected 0", cyc, Busy);
      end
    end
    t0 = cyc;
    push_exp(8'hE7, 8'h18, 8'h69, 8'h9B, t0 + 32);
    send_group(8'hE7, 8'h18, 8'h69, 8'h9B, 32, -1, -1, -1, 1'b0);
    check_drained("reset_mid_restart");
    $display("test_reset_mid: restart=%0d Q=%h/%h/%h/%h", t0, Q3, Q2, Q1, Q0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_nominal();
    test_back_to_back();
    test_en_gaps();
    test_misaligned_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
